// File: rtl/liteeth_sram_fifo_ctrl.sv
// Streaming FIFO controller for an external 1RW1R SRAM: ingress writes via the RW port,
// egress reads via the R port, with a 2-entry prefetch buffer hiding the registered read latency.
module liteeth_sram_fifo_ctrl #(
    parameter int BITS       = 32,
    parameter int WORD_DEPTH = 384,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BITS-1:0]       s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [BITS-1:0]       m_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  mem_ce_rw,
    output logic                  mem_we,
    output logic [BITS-1:0]       mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_addr_rw,
    output logic [BITS-1:0]       mem_wdata,
    output logic                  mem_ce_r,
    output logic [ADDR_WIDTH-1:0] mem_addr_r,
    input  logic [BITS-1:0]       mem_rdata
);
    // Both streams use valid/ready: a word transfers on a rising edge where valid && ready;
    // valid and data stay stable until that edge, and ready may depend combinationally on state.
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(WORD_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [BITS-1:0]       obuf_q [2];
    logic [BITS-1:0]       obuf_d [2];
    logic                  head_q, head_d;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;

    logic       clr;
    logic       wr_fire;
    logic       pop;
    logic       issue;
    logic       tail;
    logic [2:0] committed;

    always_comb begin
        clr       = !rst_n || flush;
        s_ready   = (mem_cnt_q != DEPTH_CNT) && rst_n && !flush;
        wr_fire   = s_valid && s_ready;
        m_valid   = (obuf_cnt_q != 2'd0);
        m_data    = obuf_q[head_q];
        pop       = m_valid && m_ready;
        // Slots already spoken for in the output buffer once this cycle's pop is taken out.
        committed = {1'b0, obuf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        issue     = (mem_cnt_q != '0) && (committed < 3'd2) && !clr;
        tail      = head_q + obuf_cnt_q[0];

        mem_ce_rw   = wr_fire;
        mem_we      = wr_fire;
        mem_wmask   = '1;
        mem_addr_rw = wr_ptr_q;
        mem_wdata   = s_data;
        mem_ce_r    = issue;
        mem_addr_r  = rd_ptr_q;

        level = {1'b0, mem_cnt_q} + (ADDR_WIDTH + 2)'(rd_pend_q) + (ADDR_WIDTH + 2)'(obuf_cnt_q);

        wr_ptr_d = wr_ptr_q;
        if (wr_fire) wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q;
        if (issue) rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;

        mem_cnt_d = mem_cnt_q + (ADDR_WIDTH + 1)'(wr_fire) - (ADDR_WIDTH + 1)'(issue);
        rd_pend_d = issue;

        obuf_d[0] = obuf_q[0];
        obuf_d[1] = obuf_q[1];
        if (rd_pend_q) obuf_d[tail] = mem_rdata;
        head_d     = pop ? ~head_q : head_q;
        obuf_cnt_d = obuf_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    end

    always_ff @(posedge clk0) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            rd_pend_q  <= 1'b0;
            obuf_q[0]  <= '0;
            obuf_q[1]  <= '0;
            head_q     <= 1'b0;
            obuf_cnt_q <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            rd_pend_q  <= rd_pend_d;
            obuf_q[0]  <= obuf_d[0];
            obuf_q[1]  <= obuf_d[1];
            head_q     <= head_d;
            obuf_cnt_q <= obuf_cnt_d;
        end
    end
endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Bench for liteeth_sram_fifo_ctrl: behavioural 1RW1R SRAM, a short vector table for the
// cycle-exact start-up behaviour, then scoreboarded sequences for latency, fill, wrap, flush.
module tb_liteeth_sram_fifo_ctrl;
    localparam int BITS = 32;
    localparam int DEPTH = 384;
    localparam int AW = 9;

    logic            clk0 = 1'b0;
    logic            rst_n, flush, s_valid, s_ready, m_valid, m_ready;
    logic [BITS-1:0] s_data, m_data, mem_wmask, mem_wdata, mem_rdata;
    logic [AW+1:0]   level;
    logic            mem_ce_rw, mem_we, mem_ce_r;
    logic [AW-1:0]   mem_addr_rw, mem_addr_r;

    logic [BITS-1:0] sram [512];
    logic [BITS-1:0] exp_q [$];
    int total = 0;
    int bad = 0;

    typedef struct {
        logic        flush;
        logic        s_valid;
        logic [31:0] s_data;
        logic        m_ready;
        logic        exp_s_ready;
        logic        exp_we;
        logic        exp_m_valid;
        logic [31:0] exp_m_data;
        int          exp_level;
    } vec_t;
    vec_t vecs [14];

    liteeth_sram_fifo_ctrl #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk0(clk0), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level),
        .mem_ce_rw(mem_ce_rw), .mem_we(mem_we), .mem_wmask(mem_wmask),
        .mem_addr_rw(mem_addr_rw), .mem_wdata(mem_wdata),
        .mem_ce_r(mem_ce_r), .mem_addr_r(mem_addr_r), .mem_rdata(mem_rdata)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) begin
        if (mem_ce_rw && mem_we) sram[mem_addr_rw] <= mem_wdata;
        if (mem_ce_r) mem_rdata <= sram[mem_addr_r];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, track handshakes in the scoreboard.
    task automatic step(input logic sv, input logic [31:0] sd, input logic mr);
        @(negedge clk0);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        if (mem_ce_rw) check("wr_addr_range", 32'(mem_addr_rw < AW'(DEPTH)), 32'd1);
        if (mem_ce_r) check("rd_addr_range", 32'(mem_addr_r < AW'(DEPTH)), 32'd1);
        if (m_valid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_word: got %0h expected none", m_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    bad++;
                    $display("FAIL stream_data: got %0h expected %0h", m_data, e);
                end
            end
        end
        if (s_valid && s_ready) exp_q.push_back(s_data);
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            step(1'b0, 32'd0, 1'b1);
            cyc++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check({name, "_level0"}, 32'(level), 32'd0);
    endtask

    task automatic load(input int n, input logic [31:0] base);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 2000) begin
            step(1'b1, base + 32'(acc), 1'b0);
            if (s_ready) acc++;
            cyc++;
        end
        check("load_count", 32'(acc), 32'(n));
    endtask

    initial begin
        vecs[0]  = '{0, 1, 32'hA1, 0, 1, 1, 0, 32'h0, 0};
        vecs[1]  = '{0, 1, 32'hA2, 0, 1, 1, 0, 32'h0, 1};
        vecs[2]  = '{0, 0, 32'h0,  0, 1, 0, 0, 32'h0, 2};
        vecs[3]  = '{0, 0, 32'h0,  0, 1, 0, 1, 32'hA1, 2};
        vecs[4]  = '{0, 0, 32'h0,  1, 1, 0, 1, 32'hA1, 2};
        vecs[5]  = '{0, 0, 32'h0,  1, 1, 0, 1, 32'hA2, 1};
        vecs[6]  = '{0, 1, 32'hA3, 1, 1, 1, 0, 32'h0, 0};
        vecs[7]  = '{1, 1, 32'hA4, 1, 0, 0, 0, 32'h0, 1};
        vecs[8]  = '{0, 0, 32'h0,  1, 1, 0, 0, 32'h0, 0};
        vecs[9]  = '{0, 1, 32'hA5, 1, 1, 1, 0, 32'h0, 0};
        vecs[10] = '{0, 0, 32'h0,  1, 1, 0, 0, 32'h0, 1};
        vecs[11] = '{0, 0, 32'h0,  1, 1, 0, 0, 32'h0, 1};
        vecs[12] = '{0, 0, 32'h0,  1, 1, 0, 1, 32'hA5, 1};
        vecs[13] = '{0, 0, 32'h0,  0, 1, 0, 0, 32'h0, 0};

        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk0); #1;
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_level", 32'(level), 32'd0);
            check("rst_s_ready", 32'(s_ready), 32'd0);
        end
        check("wmask_ones", mem_wmask, 32'hFFFF_FFFF);
        @(negedge clk0);
        rst_n = 1'b1; s_valid = 1'b0;
        #1;
        check("release_s_ready", 32'(s_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk0);
            flush = vecs[i].flush; s_valid = vecs[i].s_valid;
            s_data = vecs[i].s_data; m_ready = vecs[i].m_ready;
            #1;
            check($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].exp_s_ready));
            check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].exp_m_valid));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            if (vecs[i].exp_m_valid) check($sformatf("vec%0d_m_data", i), m_data, vecs[i].exp_m_data);
        end
        flush = 1'b0;

        // Latency: accepted at edge N, visible only after edge N+2.
        step(1'b1, 32'hDEAD_BEEF, 1'b1);
        check("lat_accept", 32'(s_ready), 32'd1);
        step(1'b0, 32'd0, 1'b1);
        check("lat_n1_m_valid", 32'(m_valid), 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check("lat_n2_m_valid", 32'(m_valid), 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check("lat_n3_m_valid", 32'(m_valid), 32'd1);
        drain("lat");

        // Fill to full capacity with the consumer stalled.
        load(DEPTH + 2, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hBAD0_0000, 1'b0);
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_level", 32'(level), 32'(DEPTH + 2));
        check("full_we", 32'(mem_we), 32'd0);
        drain("fill");

        // Wrap: deep backlog, then a long stream against a randomly stalled consumer.
        load(380, 32'h2000_0000);
        begin
            int sent = 0;
            int cyc = 0;
            while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
                step(1'(sent < 1000), 32'h1000_0000 + 32'(sent), 1'($urandom_range(0, 1)));
                if (s_valid && s_ready) sent++;
                cyc++;
            end
            check("wrap_sent", 32'(sent), 32'd1000);
            check("wrap_left", 32'(exp_q.size()), 32'd0);
        end
        drain("wrap");

        // Concurrency: steady level with one word in and one out per cycle.
        load(10, 32'h3000_0000);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
        check("conc_level_start", 32'(level), 32'd10);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 32'h4000_0000 + 32'(i), 1'b1);
            check("conc_level", 32'(level), 32'd10);
            check("conc_m_valid", 32'(m_valid), 32'd1);
            check("conc_s_ready", 32'(s_ready), 32'd1);
        end
        drain("conc");

        // Flush while a read is in flight: the returning word must never appear.
        step(1'b1, 32'hCAFE_F00D, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        @(negedge clk0);
        s_valid = 1'b0; flush = 1'b1;
        #1;
        check("flush_pend_level", 32'(level), 32'd1);
        check("flush_pend_m_valid", 32'(m_valid), 32'd0);
        check("flush_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk0);
        flush = 1'b0;
        exp_q.delete();
        #1;
        check("flush_m_valid", 32'(m_valid), 32'd0);
        check("flush_level", 32'(level), 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check("flush_stale_m_valid", 32'(m_valid), 32'd0);
        check("flush_stale_level", 32'(level), 32'd0);
        step(1'b1, 32'h7777_1234, 1'b1);
        drain("post_flush");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
